// File: rtl/trunc_narrow_pipe.sv
// Narrowing pipeline stage: converts WIN-bit items to WOUT bits (truncate or saturate),
// buffers two items with a registered ready, and tracks how many accepted items lost data.
module trunc_narrow_pipe #(
    parameter int unsigned WIN    = 4,
    parameter int unsigned WOUT   = 3,
    parameter int unsigned SAT    = 0,
    parameter int unsigned SIGNED = 0,
    parameter int unsigned CW     = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [WIN-1:0]  in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [WOUT-1:0] out_data,
    output logic            out_lost,
    input  logic            clr,
    output logic [CW-1:0]   lost_count,
    output logic            lost_sticky
);

    logic            in_loss;
    logic [WOUT-1:0] in_narrow;

    // Loss and narrowed value are fixed at acceptance and travel with the item.
    if (WIN > WOUT) begin : g_trunc
        logic            loss;
        logic [WOUT-1:0] sat_val;
        if (SIGNED != 0) begin : g_s
            localparam logic [WOUT-1:0] SMAX = {WOUT{1'b1}} >> 1;
            localparam logic [WOUT-1:0] SMIN = ~SMAX;
            assign loss    = ~(&in_data[WIN-1:WOUT-1]) & (|in_data[WIN-1:WOUT-1]);
            assign sat_val = in_data[WIN-1] ? SMIN : SMAX;
        end else begin : g_u
            assign loss    = |in_data[WIN-1:WOUT];
            assign sat_val = '1;
        end
        assign in_loss   = loss;
        assign in_narrow = ((SAT != 0) && loss) ? sat_val : in_data[WOUT-1:0];
    end else if (WIN == WOUT) begin : g_same
        assign in_loss   = 1'b0;
        assign in_narrow = in_data;
    end else begin : g_ext
        logic ext;
        assign ext       = (SIGNED != 0) ? in_data[WIN-1] : 1'b0;
        assign in_loss   = 1'b0;
        assign in_narrow = {{(WOUT-WIN){ext}}, in_data};
    end

    logic [WOUT-1:0] data_q [2];
    logic [1:0]      lost_q;
    logic            rd_ptr_q;
    logic            wr_ptr_q;
    logic [1:0]      count_q;
    logic [1:0]      count_d;
    logic            in_ready_q;
    logic            push;
    logic            pop;
    logic [CW-1:0]   lost_count_q;
    logic            lost_sticky_q;

    assign push        = in_valid & in_ready_q;
    assign pop         = out_valid & out_ready;
    assign out_valid   = (count_q != 2'd0);
    assign in_ready    = in_ready_q;
    assign out_data    = data_q[rd_ptr_q];
    assign out_lost    = lost_q[rd_ptr_q];
    assign lost_count  = lost_count_q;
    assign lost_sticky = lost_sticky_q;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
    end

    // in_ready is registered from next occupancy so out_ready never reaches it combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q[0]  <= '0;
            data_q[1]  <= '0;
            lost_q     <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            in_ready_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            in_ready_q <= (count_d < 2'd2);
            if (push) begin
                data_q[wr_ptr_q] <= in_narrow;
                lost_q[wr_ptr_q] <= in_loss;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lost_count_q  <= '0;
            lost_sticky_q <= 1'b0;
        end else if (clr) begin
            lost_count_q  <= '0;
            lost_sticky_q <= 1'b0;
        end else if (push && in_loss) begin
            if (lost_count_q != '1) begin
                lost_count_q <= lost_count_q + CW'(1);
            end
            lost_sticky_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_trunc_narrow_pipe.sv
// Bench for trunc_narrow_pipe: four parameter variants share one stimulus stream and are
// compared every cycle against an arithmetic model, plus literal checks of known cases.
module tb_trunc_narrow_pipe;

    localparam int CWIN  [4] = '{4, 4, 4, 3};
    localparam int CWOUT [4] = '{3, 3, 3, 5};
    localparam int CSAT  [4] = '{0, 1, 0, 1};
    localparam int CSGN  [4] = '{0, 1, 0, 1};
    localparam int CCW   [4] = '{8, 8, 2, 8};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] in_data = 4'd0;

    logic [3:0] rdy, ov, ol, st;
    logic [2:0] od0, od1, od2;
    logic [4:0] od3;
    logic [7:0] lc0, lc1, lc3;
    logic [1:0] lc2;
    int         a_data [4];
    int         a_cnt  [4];

    always #5 clk = ~clk;

    assign a_data[0] = int'(od0);
    assign a_data[1] = int'(od1);
    assign a_data[2] = int'(od2);
    assign a_data[3] = int'(od3);
    assign a_cnt[0]  = int'(lc0);
    assign a_cnt[1]  = int'(lc1);
    assign a_cnt[2]  = int'(lc2);
    assign a_cnt[3]  = int'(lc3);

    trunc_narrow_pipe #(.WIN(4), .WOUT(3), .SAT(0), .SIGNED(0), .CW(8)) u_d0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .in_data(in_data),
        .out_valid(ov[0]), .out_ready(out_ready), .out_data(od0), .out_lost(ol[0]),
        .clr(clr), .lost_count(lc0), .lost_sticky(st[0]));

    trunc_narrow_pipe #(.WIN(4), .WOUT(3), .SAT(1), .SIGNED(1), .CW(8)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .in_data(in_data),
        .out_valid(ov[1]), .out_ready(out_ready), .out_data(od1), .out_lost(ol[1]),
        .clr(clr), .lost_count(lc1), .lost_sticky(st[1]));

    trunc_narrow_pipe #(.WIN(4), .WOUT(3), .SAT(0), .SIGNED(0), .CW(2)) u_d2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]), .in_data(in_data),
        .out_valid(ov[2]), .out_ready(out_ready), .out_data(od2), .out_lost(ol[2]),
        .clr(clr), .lost_count(lc2), .lost_sticky(st[2]));

    trunc_narrow_pipe #(.WIN(3), .WOUT(5), .SAT(1), .SIGNED(1), .CW(8)) u_d3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[3]), .in_data(in_data[2:0]),
        .out_valid(ov[3]), .out_ready(out_ready), .out_data(od3), .out_lost(ol[3]),
        .clr(clr), .lost_count(lc3), .lost_sticky(st[3]));

    int nvec  = 0;
    int nfail = 0;

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Narrowing as range arithmetic: does the value fit in WOUT bits, else clamp or wrap.
    function automatic void narrow(input int k, input int x, output int d, output bit l);
        int v, lo, hi;
        v = x & ((1 << CWIN[k]) - 1);
        if (CSGN[k] != 0 && v >= (1 << (CWIN[k] - 1))) v = v - (1 << CWIN[k]);
        lo = (CSGN[k] != 0) ? -(1 << (CWOUT[k] - 1)) : 0;
        hi = (CSGN[k] != 0) ? (1 << (CWOUT[k] - 1)) - 1 : (1 << CWOUT[k]) - 1;
        l  = (v < lo) || (v > hi);
        if (CSAT[k] != 0 && l) v = (v < lo) ? lo : hi;
        d = v & ((1 << CWOUT[k]) - 1);
    endfunction

    int mq [$];
    int mcnt [4] = '{0, 0, 0, 0};
    bit mst  [4] = '{0, 0, 0, 0};
    bit mstarted = 1'b0;
    bit m_push, m_pop, m_l;
    int m_d;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            for (int k = 0; k < 4; k++) begin
                mcnt[k] = 0;
                mst[k]  = 1'b0;
            end
            mstarted = 1'b0;
        end else begin
            m_push = in_valid && mstarted && (mq.size() < 2);
            m_pop  = (mq.size() != 0) && out_ready;
            for (int k = 0; k < 4; k++) begin
                narrow(k, int'(in_data), m_d, m_l);
                if (clr) begin
                    mcnt[k] = 0;
                    mst[k]  = 1'b0;
                end else if (m_push && m_l) begin
                    if (mcnt[k] < (1 << CCW[k]) - 1) mcnt[k] = mcnt[k] + 1;
                    mst[k] = 1'b1;
                end
            end
            if (m_pop) void'(mq.pop_front());
            if (m_push) mq.push_back(int'(in_data));
            mstarted = 1'b1;
        end
    end

    int c_d;
    bit c_l;

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("d%0d.in_ready", k), int'(rdy[k]),
                int'(mstarted && !rst && mq.size() < 2));
            chk($sformatf("d%0d.out_valid", k), int'(ov[k]), int'(mq.size() != 0));
            if (mq.size() != 0) begin
                narrow(k, mq[0], c_d, c_l);
                chk($sformatf("d%0d.out_data", k), a_data[k], c_d);
                chk($sformatf("d%0d.out_lost", k), int'(ol[k]), int'(c_l));
            end
            chk($sformatf("d%0d.lost_count", k), a_cnt[k], mcnt[k]);
            chk($sformatf("d%0d.lost_sticky", k), int'(st[k]), int'(mst[k]));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) step();
        rst = 1'b0;
        chk("rel_in_ready_low", int'(rdy[0]), 0);
        step();
        chk("rst_in_ready", int'(rdy[0]), 1);
        chk("rst_out_valid", int'(ov[0]), 0);
        chk("rst_out_data", a_data[0], 0);
        chk("rst_out_lost", int'(ol[0]), 0);
        chk("rst_count", a_cnt[0], 0);

        // Default truncation of 4'b1010
        out_ready = 1'b1; in_valid = 1'b1; in_data = 4'b1010;
        step();
        in_valid = 1'b0;
        chk("lit_1010_data", a_data[0], 2);
        chk("lit_1010_lost", int'(ol[0]), 1);
        chk("lit_1010_cnt", a_cnt[0], 1);
        chk("lit_1010_sticky", int'(st[0]), 1);
        chk("lit_1010_sat_signed", a_data[1], 4);
        step();

        // Signed saturation
        clr = 1'b1; step(); clr = 1'b0;
        in_valid = 1'b1; in_data = 4'b1000; step();
        chk("lit_s1000_data", a_data[1], 4);
        chk("lit_s1000_lost", int'(ol[1]), 1);
        in_data = 4'b0111; step();
        chk("lit_s0111_data", a_data[1], 3);
        chk("lit_s0111_lost", int'(ol[1]), 1);
        in_data = 4'b1110; step();
        chk("lit_s1110_data", a_data[1], 6);
        chk("lit_s1110_lost", int'(ol[1]), 0);
        chk("lit_s_cnt", a_cnt[1], 2);
        in_valid = 1'b0; step();

        // Backpressure: fill, stall, drain in order
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 4'd1; step();
        in_data = 4'd2; step();
        in_data = 4'd3; step();
        chk("lit_full_in_ready", int'(rdy[0]), 0);
        chk("lit_full_head", a_data[0], 1);
        out_ready = 1'b1; step();
        chk("lit_drain_2", a_data[0], 2);
        step();
        chk("lit_drain_3", a_data[0], 3);
        in_valid = 1'b0; step();
        chk("lit_drain_empty", int'(ov[0]), 0);

        // Counter saturation at CW=2 and clr priority over a lossy accept
        clr = 1'b1; step(); clr = 1'b0;
        in_valid = 1'b1; in_data = 4'b1000;
        repeat (5) step();
        chk("lit_cw2_cnt", a_cnt[2], 3);
        chk("lit_cw2_sticky", int'(st[2]), 1);
        clr = 1'b1; step(); clr = 1'b0;
        chk("lit_clr_cnt", a_cnt[2], 0);
        chk("lit_clr_sticky", int'(st[2]), 0);
        in_valid = 1'b0; step();

        // Reset with two items buffered
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 4'b1001; step();
        in_data = 4'b0110; step();
        in_valid = 1'b0;
        chk("lit_prerst_valid", int'(ov[0]), 1);
        chk("lit_prerst_cnt", a_cnt[0], 1);
        rst = 1'b1; #1;
        chk("lit_rst_valid", int'(ov[0]), 0);
        chk("lit_rst_cnt", a_cnt[0], 0);
        chk("lit_rst_ready", int'(rdy[0]), 0);
        step(); step();
        rst = 1'b0; step();
        in_valid = 1'b1; in_data = 4'b0101; out_ready = 1'b1; step();
        in_valid = 1'b0;
        chk("lit_postrst_valid", int'(ov[0]), 1);
        chk("lit_postrst_data", a_data[0], 5);
        chk("lit_ext_data", a_data[3], 29);
        chk("lit_ext_lost", int'(ol[3]), 0);
        step();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_data   = 4'($urandom);
            clr       = ($urandom_range(0, 60) == 0);
            rst       = ($urandom_range(0, 150) == 0);
            step();
        end
        rst = 1'b0; clr = 1'b0; in_valid = 1'b0;
        repeat (4) step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/trunc_narrow_pipe.md
TRUNC_NARROW_PIPE -- requirements
Module: trunc_narrow_pipe

Interface
REQ-001 SHALL have parameter WIN, default 4, input data width (>=1).
REQ-002 SHALL have parameter WOUT, default 3, output data width (>=1).
REQ-003 SHALL have parameter SAT, default 0: 0 = truncate, 1 = saturate on loss.
REQ-004 SHALL have parameter SIGNED, default 0: 0 = unsigned, 1 = two's-complement operands.
REQ-005 SHALL have parameter CW, default 8, width of lost-event counter.
REQ-006 SHALL have port clk  input  1  sole clock, rising edge.
REQ-007 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port in_valid  input  1  producer offers in_data.
REQ-009 SHALL have port in_ready  output  1  block can accept this cycle.
REQ-010 SHALL have port in_data  input  WIN  value to narrow.
REQ-011 SHALL have port out_valid  output  1  out_data/out_lost valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts this cycle.
REQ-013 SHALL have port out_data  output  WOUT  narrowed value.
REQ-014 SHALL have port out_lost  output  1  current output item lost information.
REQ-015 SHALL have port clr  input  1  synchronous clear of lost_count and lost_sticky.
REQ-016 SHALL have port lost_count  output  CW  saturating count of accepted lossy items.
REQ-017 SHALL have port lost_sticky  output  1  set once any lossy item accepted.

Function
REQ-018 SHALL accept an item when in_valid & in_ready, and deliver it when out_valid & out_ready.
REQ-019 SHALL buffer exactly 2 items in FIFO order; in_ready = (occupancy < 2), registered, no combinational path from out_ready.
REQ-020 SHALL present an item accepted into an empty buffer on out_valid the next cycle (latency 1).
REQ-021 SHALL allow simultaneous accept and deliver at occupancy 1 or 2 with occupancy unchanged and order preserved.
REQ-022 SHALL hold out_data/out_lost stable while out_valid & !out_ready.
REQ-023 Loss, unsigned: any in_data bit at index >= WOUT is 1.
REQ-024 Loss, signed: in_data bits [WIN-1:WOUT-1] not all equal.
REQ-025 When WIN <= WOUT: loss SHALL be 0; out_data zero-extended (SIGNED=0) or sign-extended (SIGNED=1).
REQ-026 SAT=0: out_data SHALL be in_data[WOUT-1:0] regardless of loss.
REQ-027 SAT=1 on loss: unsigned -> all ones; signed positive -> 0 then WOUT-1 ones; signed negative -> 1 then WOUT-1 zeros.
REQ-028 SHALL compute loss and narrowed value at acceptance and store them with the item.
REQ-029 lost_count SHALL increment by 1 per accepted lossy item, holding at 2^CW-1.
REQ-030 lost_sticky SHALL set on the first accepted lossy item and hold until clr or rst.
REQ-031 clr SHALL take priority: a lossy accept in the clr cycle leaves lost_count 0 and lost_sticky 0; buffer contents unaffected.

Reset
REQ-032 rst SHALL asynchronously force occupancy 0, out_valid 0, in_ready 1 the cycle after release, out_data 0, out_lost 0, lost_count 0, lost_sticky 0.
REQ-033 rst mid-transfer SHALL discard buffered items; no item SHALL be delivered after reset that was accepted before it.
REQ-034 With rst high, in_ready SHALL be 0.

Verification
REQ-035 Defaults, out_ready=1: in_data 4'b1010 -> next cycle out_data 3'b010, out_lost 1, lost_count 1, lost_sticky 1.
REQ-036 SAT=1, SIGNED=1: inputs 4'b1000, 4'b0111, 4'b1110 -> out_data 3'b100/3'b011/3'b110, out_lost 1/1/0, lost_count 2.
REQ-037 out_ready=0, in_valid held, data 1,2,3 -> 2 accepted, in_ready 0; out_ready=1 -> outputs 1,2 then 3 in order, no drop or duplicate.
REQ-038 CW=2: five lossy items accepted -> lost_count 3, lost_sticky 1; clr pulse with lossy accept -> count 0, sticky 0.
REQ-039 rst asserted with 2 items buffered -> out_valid 0 immediately, lost_count 0; after release, first out_data equals first post-reset input.
REQ-040 WIN=3, WOUT=5, SIGNED=1: 3'b101 -> out_data 5'b11101, out_lost 0.
